// File: rtl/serial_word_negator_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | serial_word_negator_if : serial bit-in / serial+parallel result bundle  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface serial_word_negator_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in;
   logic [1:0]       mode;
   logic             out;
   logic             out_valid;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             busy;
   logic             ovf;

   modport master (
      output in_valid, in, mode,
      input  out, out_valid, word_out, word_valid, busy, ovf
   );

   modport slave (
      input  in_valid, in, mode,
      output out, out_valid, word_out, word_valid, busy, ovf
   );
endinterface
`default_nettype wire

// File: rtl/serial_word_negator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | serial_word_negator : LSB-first PASS/NEG/ABS word processor             |
// | Optional overflow flag built only with `define SERIAL_NEG_OVF_EN. Rev 1.0|
// +-------------------------------------------------------------------------+
module serial_word_negator #(
   parameter int WIDTH = 8
) (
   input wire logic             clk,
   input wire logic             rst,
   serial_word_negator_if.slave bus
);
   localparam int         CW        = $clog2(WIDTH);
   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic             seen_one;
   logic [1:0]       lmode;
   logic [WIDTH-1:0] raw_sr;
   logic [WIDTH-1:0] neg_sr;
   logic             out_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] word_q;
   logic             word_valid_q;

   logic             first_bit;
   logic [1:0]       eff_mode;
   logic             eff_seen;
   logic             neg_bit;
   logic             last_bit;
   logic [WIDTH-1:0] raw_next;
   logic [WIDTH-1:0] neg_next;
   logic [WIDTH-1:0] result;

   // The first bit of a word must see the incoming mode and a cleared seen_one
   // in the same cycle they are being latched, hence the bypass muxes.
   always_comb begin
      first_bit = (state == IDLE);
      eff_mode  = first_bit ? bus.mode : lmode;
      eff_seen  = first_bit ? 1'b0 : seen_one;
      neg_bit   = eff_seen ? ~bus.in : bus.in;
      last_bit  = (count == CW'(WIDTH - 1));
      raw_next  = {bus.in, raw_sr[WIDTH-1:1]};
      neg_next  = {neg_bit, neg_sr[WIDTH-1:1]};
      case (eff_mode)
         MODE_NEG: result = neg_next;
         MODE_ABS: result = raw_next[WIDTH-1] ? neg_next : raw_next;
         default:  result = raw_next;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         seen_one     <= 1'b0;
         lmode        <= MODE_PASS;
         raw_sr       <= '0;
         neg_sr       <= '0;
         out_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         out_valid_q  <= bus.in_valid;
         word_valid_q <= 1'b0;
         if (bus.in_valid) begin
            out_q    <= (eff_mode == MODE_NEG) ? neg_bit : bus.in;
            seen_one <= eff_seen | bus.in;
            raw_sr   <= raw_next;
            neg_sr   <= neg_next;
            case (state)
               IDLE: begin
                  lmode <= bus.mode;
                  count <= CW'(1);
                  state <= RUN;
               end
               RUN: begin
                  if (last_bit) begin
                     count        <= '0;
                     state        <= IDLE;
                     word_q       <= result;
                     word_valid_q <= 1'b1;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.out        = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.word_out   = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.busy       = (count != '0);

`ifdef SERIAL_NEG_OVF_EN
   localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};
   logic ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= bus.in_valid && (state == RUN) && last_bit &&
                  ((eff_mode == MODE_NEG) || (eff_mode == MODE_ABS)) &&
                  (raw_next == MIN_WORD);
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_word_negator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_serial_word_negator : directed self-checking bench, WIDTH=8. Rev 1.0 |
// +-------------------------------------------------------------------------+
module tb_serial_word_negator;
   localparam int         WIDTH = 8;
   localparam logic [1:0] PASS  = 2'b00;
   localparam logic [1:0] NEG   = 2'b01;
   localparam logic [1:0] ABS   = 2'b10;
`ifdef SERIAL_NEG_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   serial_word_negator_if #(.WIDTH(WIDTH)) bus ();
   serial_word_negator #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #10 clk = ~clk;

   logic             ser_q[$];
   logic [WIDTH-1:0] word_q[$];
   logic             ovf_q[$];

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) ser_q.push_back(bus.out);
      if (bus.word_valid === 1'b1) begin
         word_q.push_back(bus.word_out);
         ovf_q.push_back(bus.ovf);
      end
   end

   task automatic clear_logs();
      ser_q.delete();
      word_q.delete();
      ovf_q.delete();
   endtask

   task automatic drive_bit(input logic b, input logic [1:0] m);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in       = b;
      bus.mode     = m;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input logic [1:0] m);
      for (int i = 0; i < 8; i++) drive_bit(w[i], m);
   endtask

   task automatic test_reset();
      logic [12:0] got;
      got = {bus.out, bus.out_valid, bus.word_out, bus.word_valid, bus.busy, bus.ovf};
      tests++;
      if (got !== 13'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0", got);
      end
   endtask

   task automatic test_neg();
      logic [7:0] exp_ser;
      exp_ser = 8'hD6;
      clear_logs();
      send_word(8'h2A, NEG);
      idle(1);
      tests++;
      if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hD6) begin
         fails++;
         $display("FAIL neg_word: valid %b word %h expected valid 1 word d6", bus.word_valid, bus.word_out);
      end
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL neg_last_out_valid: got %b expected 1", bus.out_valid);
      end
      idle(1);
      tests++;
      if (bus.word_valid !== 1'b0) begin
         fails++;
         $display("FAIL neg_pulse_width: got %b expected 0", bus.word_valid);
      end
      tests++;
      if (ser_q.size() != 8) begin
         fails++;
         $display("FAIL neg_ser_count: got %0d expected 8", ser_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (ser_q[i] !== exp_ser[i]) begin
            fails++;
            $display("FAIL neg_ser_bit%0d: got %b expected %b", i, ser_q[i], exp_ser[i]);
         end
      end
   endtask

   task automatic test_abs();
      logic [7:0] exp_ser;
      exp_ser = 8'hF3;
      clear_logs();
      send_word(8'hF3, ABS);
      idle(2);
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (ser_q[i] !== exp_ser[i]) begin
            fails++;
            $display("FAIL abs_ser_bit%0d: got %b expected %b", i, ser_q[i], exp_ser[i]);
         end
      end
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'h0D || ovf_q[0] !== 1'b0) begin
         fails++;
         $display("FAIL abs_neg_word: n %0d word %h ovf %b expected n 1 word 0d ovf 0", word_q.size(), word_q[0], ovf_q[0]);
      end
      clear_logs();
      send_word(8'h35, ABS);
      idle(2);
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'h35) begin
         fails++;
         $display("FAIL abs_pos_word: n %0d word %h expected n 1 word 35", word_q.size(), word_q[0]);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] w;
      logic       exp_busy;
      w = 8'h5C;
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         drive_bit(w[i], PASS);
         exp_busy = (i != 7);
         idle(1);
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out !== w[i] || bus.busy !== exp_busy) begin
            fails++;
            $display("FAIL gap_bit%0d: ov %b out %b busy %b expected ov 1 out %b busy %b", i, bus.out_valid, bus.out, bus.busy, w[i], exp_busy);
         end
         repeat (2) begin
            idle(1);
            tests++;
            if (bus.out_valid !== 1'b0 || bus.busy !== exp_busy) begin
               fails++;
               $display("FAIL gap_idle%0d: ov %b busy %b expected ov 0 busy %b", i, bus.out_valid, bus.busy, exp_busy);
            end
         end
      end
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'h5C) begin
         fails++;
         $display("FAIL gap_word: n %0d word %h expected n 1 word 5c", word_q.size(), word_q[0]);
      end
   endtask

   task automatic test_ovf();
      clear_logs();
      send_word(8'h80, NEG);
      idle(2);
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'h80 || ovf_q[0] !== OVF_EXP) begin
         fails++;
         $display("FAIL ovf_min_word: n %0d word %h ovf %b expected n 1 word 80 ovf %b", word_q.size(), word_q[0], ovf_q[0], OVF_EXP);
      end
      tests++;
      if (bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL ovf_pulse_width: got %b expected 0", bus.ovf);
      end
      clear_logs();
      send_word(8'h00, NEG);
      idle(2);
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'h00 || ovf_q[0] !== 1'b0) begin
         fails++;
         $display("FAIL ovf_zero_word: n %0d word %h ovf %b expected n 1 word 00 ovf 0", word_q.size(), word_q[0], ovf_q[0]);
      end
   endtask

   task automatic test_reset_midword();
      logic [12:0] got;
      for (int i = 0; i < 3; i++) drive_bit(1'b1, NEG);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      #1;
      got = {bus.out, bus.out_valid, bus.word_out, bus.word_valid, bus.busy, bus.ovf};
      tests++;
      if (got !== 13'h0) begin
         fails++;
         $display("FAIL midword_reset_outputs: got %h expected 0", got);
      end
      clear_logs();
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      tests++;
      if (word_q.size() != 0) begin
         fails++;
         $display("FAIL midword_no_word: got %0d words expected 0", word_q.size());
      end
      send_word(8'h01, NEG);
      idle(2);
      tests++;
      if (word_q.size() != 1 || word_q[0] !== 8'hFF) begin
         fails++;
         $display("FAIL midword_fresh_word: n %0d word %h expected n 1 word ff", word_q.size(), word_q[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_ser;
      logic [7:0]  w;
      exp_ser = 16'h01FF;
      w       = 8'h01;
      clear_logs();
      send_word(8'h01, NEG);
      for (int i = 0; i < 8; i++) drive_bit(w[i], (i >= 3) ? NEG : PASS);
      idle(2);
      tests++;
      if (word_q.size() != 2 || word_q[0] !== 8'hFF || word_q[1] !== 8'h01) begin
         fails++;
         $display("FAIL b2b_words: n %0d w0 %h w1 %h expected n 2 w0 ff w1 01", word_q.size(), word_q[0], word_q[1]);
      end
      tests++;
      if (ser_q.size() != 16) begin
         fails++;
         $display("FAIL b2b_ser_count: got %0d expected 16", ser_q.size());
      end
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (ser_q[i] !== exp_ser[i]) begin
            fails++;
            $display("FAIL b2b_ser_bit%0d: got %b expected %b", i, ser_q[i], exp_ser[i]);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in       = 1'b0;
      bus.mode     = PASS;
      #195;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_neg();
      test_abs();
      test_gaps();
      test_ovf();
      test_reset_midword();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
